alu_ctrl_seq: RTL and testbench

//  Next-generation ALU controller for the rv32i core. Decodes ALUOp/Funct3/Funct7 into an OP_W-bit ALU operation, including RV32M (MUL/DIV/REM) when ENABLE_M=1.

---
 rtl/alu_ctrl_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU operation decoder for the rv32i EX stage with a valid/ready result register
// and a countdown sequencer that stalls EX while multi-cycle RV32M ops iterate.
module alu_ctrl_seq #(
    parameter int unsigned OP_W     = 5,
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 33
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] Operation,
    output logic            illegal,
    output logic            mdu_start,
    output logic            stall
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BGE  = 5'b01010;
    localparam logic [4:0] OP_BLT  = 5'b01011;
    localparam logic [4:0] OP_SLT  = 5'b01100;
    localparam logic [4:0] OP_BLTU = 5'b01101;
    localparam logic [4:0] OP_SLTU = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [OP_W-1:0]   r_op;
    logic [OP_W-1:0]   w_op_n;
    logic              r_ill;
    logic              w_ill_n;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_n;
    logic              r_start;
    logic              w_start_n;

    logic [4:0]        w_dec_op;
    logic              w_dec_ill;
    logic              w_dec_m;
    logic              w_dec_div;
    logic [CNT_W-1:0]  w_lat;
    logic              w_accept;

    // Funct3-indexed op shared by R-type (Funct7=0) and I-type immediates.
    function automatic logic [4:0] f_base_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // Instruction field decode into a 5-bit op code.
    always_comb begin
        w_dec_op  = OP_ADD;
        w_dec_ill = 1'b0;
        w_dec_m   = 1'b0;
        w_dec_div = 1'b0;
        case (ALUOp)
            2'b00: w_dec_op = OP_ADD;
            2'b01: begin
                case (Funct3)
                    3'b000:  w_dec_op = OP_BEQ;
                    3'b001:  w_dec_op = OP_BNE;
                    3'b100:  w_dec_op = OP_BLT;
                    3'b101:  w_dec_op = OP_BGE;
                    3'b110:  w_dec_op = OP_BLTU;
                    3'b111:  w_dec_op = OP_BGEU;
                    default: w_dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                if (Funct7 == F7_BASE) begin
                    w_dec_op = f_base_op(Funct3);
                end else if (Funct7 == F7_ALT) begin
                    if (Funct3 == 3'b000) begin
                        w_dec_op = OP_SUB;
                    end else if (Funct3 == 3'b101) begin
                        w_dec_op = OP_SRA;
                    end else begin
                        w_dec_ill = 1'b1;
                    end
                end else if ((Funct7 == F7_MDU) && ENABLE_M) begin
                    w_dec_op  = {2'b10, Funct3};
                    w_dec_m   = 1'b1;
                    w_dec_div = Funct3[2];
                end else begin
                    w_dec_ill = 1'b1;
                end
            end
            default: begin
                // I-type: Funct7 only qualifies the shift immediates.
                case (Funct3)
                    3'b001: begin
                        if (Funct7 == F7_BASE) w_dec_op = OP_SLL;
                        else                   w_dec_ill = 1'b1;
                    end
                    3'b101: begin
                        if (Funct7 == F7_BASE)     w_dec_op = OP_SRL;
                        else if (Funct7 == F7_ALT) w_dec_op = OP_SRA;
                        else                       w_dec_ill = 1'b1;
                    end
                    default: w_dec_op = f_base_op(Funct3);
                endcase
            end
        endcase
        if (w_dec_ill) begin
            w_dec_op = OP_ADD;
        end
    end

    assign w_lat    = w_dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    assign in_ready = !flush && ((r_state == S_IDLE) || ((r_state == S_RESULT) && out_ready));
    assign w_accept = in_valid && in_ready;

    // Next-state and register-input logic.
    always_comb begin
        w_state_n = r_state;
        w_op_n    = r_op;
        w_ill_n   = r_ill;
        w_cnt_n   = r_cnt;
        w_start_n = 1'b0;
        if (flush) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    if (r_cnt == '0) w_state_n = S_RESULT;
                    else             w_cnt_n   = r_cnt - CNT_W'(1);
                end
                S_RESULT: begin
                    if (!w_accept && out_ready) w_state_n = S_IDLE;
                end
                default: ;
            endcase
            if (w_accept) begin
                w_op_n  = OP_W'(w_dec_op);
                w_ill_n = w_dec_ill;
                if (w_dec_m) begin
                    w_state_n = S_BUSY;
                    w_cnt_n   = w_lat;
                    w_start_n = 1'b1;
                end else begin
                    w_state_n = S_RESULT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_op    <= w_op_n;
            r_ill   <= w_ill_n;
            r_cnt   <= w_cnt_n;
            r_start <= w_start_n;
        end
    end

    assign Operation = r_op;
    assign illegal   = r_ill;
    assign out_valid = (r_state == S_RESULT);
    assign mdu_start = ENABLE_M && r_start;
    assign stall     = ENABLE_M && (r_state == S_BUSY);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: decode vector table, directed multi-cycle sequences,
// and random traffic against a timestamp-based reference model.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_valid2;
    logic       out_ready;
    logic [1:0] ALUOp;
    logic [6:0] Funct7;
    logic [2:0] Funct3;

    logic       in_ready,  out_valid,  illegal,  mdu_start,  stall;
    logic [4:0] Operation;
    logic       in_ready2, out_valid2, illegal2, mdu_start2, stall2;
    logic [4:0] Operation2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.OP_W(5), .ENABLE_M(1'b1), .MUL_LAT(2), .DIV_LAT(33)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .out_valid(out_valid),
        .out_ready(out_ready), .Operation(Operation), .illegal(illegal),
        .mdu_start(mdu_start), .stall(stall)
    );

    alu_ctrl_seq #(.OP_W(5), .ENABLE_M(1'b0), .MUL_LAT(2), .DIV_LAT(33)) dut_nom (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .out_valid(out_valid2),
        .out_ready(out_ready), .Operation(Operation2), .illegal(illegal2),
        .mdu_start(mdu_start2), .stall(stall2)
    );

    typedef struct {
        logic [1:0] a;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] op;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t       vecs [15];
    logic [4:0] br_tab   [8];
    logic [4:0] base_tab [8];

    // Reference model: one outstanding op described by timestamps.
    int         cyc = 0;
    logic       m_inflight = 1'b0;
    logic       m_is_m = 1'b0;
    logic [4:0] m_op = 5'd0;
    logic       m_ill = 1'b0;
    int         m_start = 0;
    int         m_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                                       output logic [4:0] op, output logic ill,
                                       output logic is_m, output int lat);
        op = 5'd2; ill = 1'b0; is_m = 1'b0; lat = 0;
        if (a == 2'b01) begin
            if (br_tab[f3] == 5'd31) ill = 1'b1;
            else                     op  = br_tab[f3];
        end else if (a == 2'b10) begin
            if (f7 == 7'h00)                         op = base_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0)      op = 5'd6;
            else if (f7 == 7'h20 && f3 == 3'd5)      op = 5'd7;
            else if (f7 == 7'h01) begin
                op = 5'd16 + 5'(f3); is_m = 1'b1; lat = (f3 >= 3'd4) ? 33 : 2;
            end else                                 ill = 1'b1;
        end else if (a == 2'b11) begin
            if (f3 == 3'd1 && f7 != 7'h00)                     ill = 1'b1;
            else if (f3 == 3'd5 && f7 == 7'h20)                op = 5'd7;
            else if (f3 == 3'd5 && f7 != 7'h00)                ill = 1'b1;
            else                                               op = base_tab[f3];
        end
        if (ill) op = 5'd2;
    endfunction

    task automatic drive(input logic iv, input logic [1:0] a, input logic [2:0] f3,
                         input logic [6:0] f7, input logic ordy, input logic fl);
        logic [4:0] dop;
        logic       dill, dm, e_ov, e_st, e_ms, e_ir;
        int         dlat;
        in_valid = iv; ALUOp = a; Funct3 = f3; Funct7 = f7; out_ready = ordy; flush = fl;
        #1;
        e_ov = m_inflight && (cyc >= m_done);
        e_st = m_inflight && m_is_m && (cyc < m_done);
        e_ms = m_inflight && m_is_m && (cyc == m_start);
        e_ir = !fl && (!m_inflight || (e_ov && ordy));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("stall", 32'(stall), 32'(e_st));
        chk("mdu_start", 32'(mdu_start), 32'(e_ms));
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        if (m_inflight) begin
            chk("Operation", 32'(Operation), 32'(m_op));
            chk("illegal", 32'(illegal), 32'(m_ill));
        end
        if (fl) begin
            m_inflight = 1'b0;
        end else if (iv && e_ir) begin
            ref_decode(a, f3, f7, dop, dill, dm, dlat);
            m_inflight = 1'b1; m_op = dop; m_ill = dill; m_is_m = dm;
            m_start = cyc + 1; m_done = cyc + 1 + dlat;
        end else if (e_ov && ordy) begin
            m_inflight = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && m_inflight; k++) drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);
        chk("drain", 32'({out_valid, stall}), 32'd0);
    endtask

    initial begin
        int         c, lat, n_st, n_ms;
        logic [6:0] f7r;

        base_tab = '{5'd2, 5'd4, 5'd12, 5'd14, 5'd3, 5'd5, 5'd1, 5'd0};
        br_tab   = '{5'd8, 5'd9, 5'd31, 5'd31, 5'd11, 5'd10, 5'd13, 5'd15};
        vecs[0]  = '{2'b00, 3'd3, 7'h55, 5'd2,  1'b0, 1};
        vecs[1]  = '{2'b01, 3'd0, 7'h00, 5'd8,  1'b0, 1};
        vecs[2]  = '{2'b01, 3'd5, 7'h00, 5'd10, 1'b0, 1};
        vecs[3]  = '{2'b01, 3'd2, 7'h00, 5'd2,  1'b1, 1};
        vecs[4]  = '{2'b10, 3'd0, 7'h20, 5'd6,  1'b0, 1};
        vecs[5]  = '{2'b10, 3'd7, 7'h00, 5'd0,  1'b0, 1};
        vecs[6]  = '{2'b10, 3'd2, 7'h20, 5'd2,  1'b1, 1};
        vecs[7]  = '{2'b10, 3'd3, 7'h01, 5'd19, 1'b0, 3};
        vecs[8]  = '{2'b10, 3'd6, 7'h7f, 5'd2,  1'b1, 1};
        vecs[9]  = '{2'b11, 3'd1, 7'h20, 5'd2,  1'b1, 1};
        vecs[10] = '{2'b11, 3'd5, 7'h20, 5'd7,  1'b0, 1};
        vecs[11] = '{2'b11, 3'd3, 7'h33, 5'd14, 1'b0, 1};
        vecs[12] = '{2'b11, 3'd6, 7'h00, 5'd1,  1'b0, 1};
        vecs[13] = '{2'b10, 3'd4, 7'h01, 5'd20, 1'b0, 34};
        vecs[14] = '{2'b01, 3'd6, 7'h00, 5'd13, 1'b0, 1};

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
        ALUOp = 2'b00; Funct7 = 7'd0; Funct3 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_Operation", 32'(Operation), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mdu_start", 32'(mdu_start), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_in_ready_nom", 32'(in_ready2), 32'd1);
        reset = 1'b1;

        // Decode table with per-op latency.
        for (int i = 0; i < 15; i++) begin
            wait_idle();
            c = cyc;
            lat = -1;
            drive(1'b1, vecs[i].a, vecs[i].f3, vecs[i].f7, 1'b0, 1'b0);
            for (int k = 0; k < 60; k++) begin
                if (out_valid) begin
                    lat = cyc - c;
                    break;
                end
                drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0, 1'b0);
            end
            chk($sformatf("vec%0d_op", i), 32'(Operation), 32'(vecs[i].op));
            chk($sformatf("vec%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);
        end

        // Branch BLTU then SRAI back-to-back.
        wait_idle();
        drive(1'b1, 2'b01, 3'd6, 7'h00, 1'b1, 1'b0);
        chk("b2b_op1", 32'(Operation), 32'd13);
        drive(1'b1, 2'b11, 3'd5, 7'h20, 1'b1, 1'b0);
        chk("b2b_op2", 32'(Operation), 32'd7);
        chk("b2b_valid2", 32'(out_valid), 32'd1);
        drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);

        // Held result while EX is not ready.
        wait_idle();
        drive(1'b1, 2'b10, 3'd0, 7'h20, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'b10, 3'd4, 7'h00, 1'b0, 1'b0);
            chk("hold_op", 32'(Operation), 32'd6);
        end
        drive(1'b1, 2'b10, 3'd4, 7'h00, 1'b1, 1'b0);
        chk("hold_next_op", 32'(Operation), 32'd3);
        drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);

        // DIV timing.
        wait_idle();
        c = cyc; lat = -1; n_st = 0; n_ms = 0;
        drive(1'b1, 2'b10, 3'd4, 7'h01, 1'b1, 1'b0);
        for (int k = 0; k < 60; k++) begin
            if (stall) n_st++;
            if (mdu_start) n_ms++;
            if (out_valid) begin
                lat = cyc - c;
                break;
            end
            drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0, 1'b0);
        end
        chk("div_stall_cycles", 32'(n_st), 32'd33);
        chk("div_start_pulses", 32'(n_ms), 32'd1);
        chk("div_latency", 32'(lat), 32'd34);
        chk("div_op", 32'(Operation), 32'd20);
        drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);

        // Flush at countdown 10 with an op offered in the same cycle.
        wait_idle();
        drive(1'b1, 2'b10, 3'd5, 7'h01, 1'b0, 1'b0);
        for (int k = 0; k < 22; k++) drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 3'd0, 7'h00, 1'b1, 1'b1);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 40; k++) drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a DIV.
        drive(1'b1, 2'b10, 3'd6, 7'h01, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_Operation", 32'(Operation), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_mdu_start", 32'(mdu_start), 32'd0);
        chk("arst_illegal", 32'(illegal), 32'd0);
        m_inflight = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b1;
        for (int k = 0; k < 40; k++) drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);

        // M-op encoding with M disabled decodes illegal, single cycle.
        in_valid2 = 1'b1;
        drive(1'b0, 2'b10, 3'd4, 7'h01, 1'b1, 1'b0);
        in_valid2 = 1'b0;
        chk("nom_out_valid", 32'(out_valid2), 32'd1);
        chk("nom_op", 32'(Operation2), 32'd2);
        chk("nom_illegal", 32'(illegal2), 32'd1);
        chk("nom_stall", 32'(stall2), 32'd0);
        chk("nom_mdu_start", 32'(mdu_start2), 32'd0);
        drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       f7r = 7'h00;
                1:       f7r = 7'h20;
                2:       f7r = 7'h01;
                default: f7r = 7'($urandom);
            endcase
            drive(1'($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom), f7r,
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
